// File: rtl/vga_stream_pkg.sv
// Shared stream layout, default 800x600@72 timing and colour constants for the VGA stream chain.
package vga_stream_pkg;

  localparam int STREAM_W = 26;
  localparam int ACTIVE_B = 0;
  localparam int VS_B     = 1;
  localparam int HS_B     = 2;
  localparam int YC_LSB   = 3;
  localparam int XC_LSB   = 13;
  localparam int R_B      = 23;
  localparam int G_B      = 24;
  localparam int B_B      = 25;
  localparam int COORD_W  = 10;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  // rgb is {B,G,R}, which lands on bits [25:23] in that order.
  function automatic logic [STREAM_W-1:0] pack_word(
    input logic [2:0]         rgb,
    input logic [COORD_W-1:0] xc,
    input logic [COORD_W-1:0] yc,
    input logic               hs,
    input logic               vs,
    input logic               active
  );
    return {rgb, xc, yc, hs, vs, active};
  endfunction

endpackage

// File: rtl/vga_stream_gen_axis_counter.sv
// Wrap counter for one raster axis: advances on i_inc, wraps TOTAL-1 -> 0 and flags the wrap.
module vga_axis_counter #(
  parameter int TOTAL = 1040,
  parameter int W     = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_count;

  assign o_wrap  = i_inc && (r_count == LAST);
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_stream_gen.sv
// Raster timing source emitting the 26-bit RGB stream word; define VGA_TESTPAT_EN for colour bars.
module vga_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic                px_clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [2:0]          bg_color,
  output logic [STREAM_W-1:0] strRGB_o,
  output logic                frame_start,
  output logic                line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] w_hc;
  logic [9:0]  w_vc;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic [2:0]  w_pix_rgb;
  logic [2:0]  w_rgb;
  logic        w_line_first;
  logic        w_frame_first;

  logic [STREAM_W-1:0] r_stream;
  logic                r_frame_start;
  logic                r_line_start;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(11)) u_h_cnt (
    .i_clk   (px_clk),
    .i_rst_n (rst_n),
    .i_inc   (en),
    .o_count (w_hc),
    .o_wrap  (w_h_wrap)
  );

  // The vertical axis steps only on the horizontal wrap, so both wrap on the same edge at frame end.
  vga_axis_counter #(.TOTAL(V_TOTAL), .W(10)) u_v_cnt (
    .i_clk   (px_clk),
    .i_rst_n (rst_n),
    .i_inc   (w_h_wrap),
    .o_count (w_vc),
    .o_wrap  (w_v_wrap)
  );

  assign w_active = (w_hc < H_ACT_END) && (w_vc < V_ACT_END);
  assign w_hs     = ((w_hc >= HS_START) && (w_hc < HS_END)) ? HS_POL : ~HS_POL;
  assign w_vs     = ((w_vc >= VS_START) && (w_vc < VS_END)) ? VS_POL : ~VS_POL;

`ifdef VGA_TESTPAT_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
  logic [10:0] w_bar_idx;
  assign w_bar_idx = w_hc / BAR_W;
  assign w_pix_rgb = COL_WHITE - w_bar_idx[2:0];
`else
  assign w_pix_rgb = bg_color;
`endif

  assign w_rgb         = w_active ? w_pix_rgb : COL_BLACK;
  assign w_line_first  = (w_hc == '0);
  assign w_frame_first = w_line_first && (w_vc == '0);

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stream      <= pack_word(COL_BLACK, '0, '0, ~HS_POL, ~VS_POL, 1'b0);
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else if (en) begin
      r_stream      <= pack_word(w_rgb, w_hc[9:0], w_vc, w_hs, w_vs, w_active);
      r_frame_start <= w_frame_first;
      r_line_start  <= w_line_first;
    end else begin
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end
  end

  assign strRGB_o    = r_stream;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

  logic w_unused;
  assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench for vga_stream_gen; horizontal timing is the real 800x600@72 line, vertical is shortened
// to a 15-line frame (8 active, FP 2, sync 3, BP 2) so whole frames fit in a short run.
module tb_vga_stream_gen;

  localparam int H_TOTAL = 1040;
  localparam int V_TOTAL = 15;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
`ifdef VGA_TESTPAT_EN
  localparam bit TESTPAT = 1'b1;
`else
  localparam bit TESTPAT = 1'b0;
`endif

  logic        px_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  bg_color = 3'b000;
  logic [25:0] strRGB_o;
  logic        frame_start;
  logic        line_start;

  int tests_run = 0;
  int tests_failed = 0;

  vga_stream_gen #(
    .V_ACTIVE (8),
    .V_FP     (2),
    .V_SYNC   (3),
    .V_BP     (2)
  ) dut (
    .px_clk      (px_clk),
    .rst_n       (rst_n),
    .en          (en),
    .bg_color    (bg_color),
    .strRGB_o    (strRGB_o),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  always #10 px_clk = ~px_clk;

  wire       s_act = strRGB_o[0];
  wire       s_vs  = strRGB_o[1];
  wire       s_hs  = strRGB_o[2];
  wire [9:0] s_yc  = strRGB_o[12:3];
  wire [9:0] s_xc  = strRGB_o[22:13];
  wire [2:0] s_rgb = strRGB_o[25:23];

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  // Expected RGB field of an active pixel at horizontal position x.
  function automatic logic [2:0] exp_rgb(input int x, input logic [2:0] bg);
    logic [2:0] bar;
    bar = 3'(7 - x / 100);
    if (TESTPAT) return bar;
    return bg;
  endfunction

  task automatic test_reset();
    logic [25:0] exp;
    rst_n = 1'b0;
    en = 1'b0;
    bg_color = 3'b101;
    repeat (10) tick();
    tests_run++;
    if (strRGB_o !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_word: got %h expected %h", strRGB_o, 26'd0);
    end
    tests_run++;
    if ({frame_start, line_start} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_pulses: got %b expected 00", {frame_start, line_start});
    end
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    exp = {exp_rgb(0, 3'b101), 10'd0, 10'd0, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (strRGB_o !== exp) begin
      tests_failed++;
      $display("FAIL first_word: got %h expected %h", strRGB_o, exp);
    end
    tests_run++;
    if ({frame_start, line_start} !== 2'b11) begin
      tests_failed++;
      $display("FAIL first_pulses: got %b expected 11", {frame_start, line_start});
    end
  endtask

  task automatic test_line();
    int n_act = 0, n_hs = 0, first_hs = -1, last_hs = -1, n_line = 0, bad_rgb = 0, bad_xc = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      if (s_act === 1'b1) begin
        n_act++;
        if (s_rgb !== exp_rgb(int'(s_xc), bg_color)) bad_rgb++;
      end else if (s_rgb !== 3'b000) begin
        bad_rgb++;
      end
      if (s_hs === 1'b1) begin
        n_hs++;
        if (first_hs < 0) first_hs = i;
        last_hs = i;
      end
      if (line_start === 1'b1) n_line++;
      if (s_xc !== 10'(i)) bad_xc++;
      tick();
    end
    tests_run++;
    if (n_act != 800) begin
      tests_failed++;
      $display("FAIL line_active_count: got %0d expected 800", n_act);
    end
    tests_run++;
    if (n_hs != 120 || first_hs != 856 || last_hs != 975) begin
      tests_failed++;
      $display("FAIL line_hsync: got count %0d first %0d last %0d expected 120 856 975", n_hs, first_hs, last_hs);
    end
    tests_run++;
    if (n_line != 1 || bad_xc != 0 || bad_rgb != 0) begin
      tests_failed++;
      $display("FAIL line_content: got line_starts %0d bad_xc %0d bad_rgb %0d expected 1 0 0", n_line, bad_xc, bad_rgb);
    end
    tests_run++;
    if (line_start !== 1'b1 || frame_start !== 1'b0 || s_xc !== 10'd0 || s_yc !== 10'd1) begin
      tests_failed++;
      $display("FAIL line_period: got ls %b fs %b xc %0d yc %0d expected 1 0 0 1", line_start, frame_start, s_xc, s_yc);
    end
  endtask

  task automatic test_frame();
    int n = 0, n_act = 0, n_vs = 0, n_vs_lines = 0, first_vs_line = -1;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != FRAME - H_TOTAL) begin
      tests_failed++;
      $display("FAIL frame_first_start: got %0d cycles expected %0d", n, FRAME - H_TOTAL);
    end
    n = 0;
    do begin
      if (s_act === 1'b1) n_act++;
      if (s_vs === 1'b1) begin
        n_vs++;
        if (line_start === 1'b1) begin
          n_vs_lines++;
          if (first_vs_line < 0) first_vs_line = int'(s_yc);
        end
      end
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    tests_run++;
    if (n != FRAME) begin
      tests_failed++;
      $display("FAIL frame_period: got %0d cycles expected %0d", n, FRAME);
    end
    tests_run++;
    if (n_act != 6400) begin
      tests_failed++;
      $display("FAIL frame_active: got %0d expected 6400", n_act);
    end
    tests_run++;
    if (n_vs != 3 * H_TOTAL || n_vs_lines != 3 || first_vs_line != 10) begin
      tests_failed++;
      $display("FAIL frame_vsync: got words %0d lines %0d first %0d expected 3120 3 10", n_vs, n_vs_lines, first_vs_line);
    end
  endtask

  task automatic test_en_hold();
    logic [25:0] exp;
    repeat (100) tick();
    exp = {exp_rgb(100, bg_color), 10'd100, 10'd0, 1'b0, 1'b0, 1'b1};
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (strRGB_o !== exp || frame_start !== 1'b0 || line_start !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_word_%0d: got %h fs %b ls %b expected %h 0 0", k, strRGB_o, frame_start, line_start, exp);
      end
    end
    en = 1'b1;
    tick();
    exp = {exp_rgb(101, bg_color), 10'd101, 10'd0, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (strRGB_o !== exp) begin
      tests_failed++;
      $display("FAIL hold_resume: got %h expected %h", strRGB_o, exp);
    end
    repeat (H_TOTAL - 101) tick();
    tests_run++;
    if (line_start !== 1'b1 || s_xc !== 10'd0 || s_yc !== 10'd1) begin
      tests_failed++;
      $display("FAIL hold_line_reach: got ls %b xc %0d yc %0d expected 1 0 1", line_start, s_xc, s_yc);
    end
    en = 1'b0;
    tick();
    exp = {exp_rgb(0, bg_color), 10'd0, 10'd1, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (line_start !== 1'b0 || frame_start !== 1'b0 || strRGB_o !== exp) begin
      tests_failed++;
      $display("FAIL hold_pulse_drop: got ls %b fs %b word %h expected 0 0 %h", line_start, frame_start, strRGB_o, exp);
    end
    en = 1'b1;
    tick();
    tests_run++;
    if (s_xc !== 10'd1 || s_yc !== 10'd1 || line_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_pulse_resume: got xc %0d yc %0d ls %b expected 1 1 0", s_xc, s_yc, line_start);
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] exp;
    repeat (4 * H_TOTAL + 499) tick();
    tests_run++;
    if (s_xc !== 10'd500 || s_yc !== 10'd5 || s_act !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_reach: got xc %0d yc %0d act %b expected 500 5 1", s_xc, s_yc, s_act);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (strRGB_o !== 26'd0 || frame_start !== 1'b0 || line_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: got %h fs %b ls %b expected 0000000 0 0", strRGB_o, frame_start, line_start);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp = {exp_rgb(0, bg_color), 10'd0, 10'd0, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (strRGB_o !== exp || frame_start !== 1'b1 || line_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_restart: got %h fs %b ls %b expected %h 1 1", strRGB_o, frame_start, line_start, exp);
    end
  endtask

  task automatic test_bg();
    bg_color = 3'b011;
    tick();
    tests_run++;
    if (s_xc !== 10'd1 || s_rgb !== exp_rgb(1, 3'b011)) begin
      tests_failed++;
      $display("FAIL bg_change: got xc %0d rgb %b expected 1 %b", s_xc, s_rgb, exp_rgb(1, 3'b011));
    end
    repeat (98) tick();
    tests_run++;
    if (s_xc !== 10'd99 || s_rgb !== exp_rgb(99, 3'b011)) begin
      tests_failed++;
      $display("FAIL bg_hc99: got xc %0d rgb %b expected 99 %b", s_xc, s_rgb, exp_rgb(99, 3'b011));
    end
    tick();
    tests_run++;
    if (s_xc !== 10'd100 || s_rgb !== exp_rgb(100, 3'b011)) begin
      tests_failed++;
      $display("FAIL bg_hc100: got xc %0d rgb %b expected 100 %b", s_xc, s_rgb, exp_rgb(100, 3'b011));
    end
    repeat (699) tick();
    tests_run++;
    if (s_xc !== 10'd799 || s_act !== 1'b1 || s_rgb !== exp_rgb(799, 3'b011)) begin
      tests_failed++;
      $display("FAIL bg_hc799: got xc %0d act %b rgb %b expected 799 1 %b", s_xc, s_act, s_rgb, exp_rgb(799, 3'b011));
    end
    tick();
    tests_run++;
    if (s_xc !== 10'd800 || s_act !== 1'b0 || s_rgb !== 3'b000) begin
      tests_failed++;
      $display("FAIL bg_blank: got xc %0d act %b rgb %b expected 800 0 000", s_xc, s_act, s_rgb);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_en_hold();
    test_reset_mid();
    test_bg();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
